// File: rtl/hop_kernel_afh_seq.sv
// rtl/hop_kernel_afh_seq.sv - sequential hop kernel with AFH remap
// Basic hop channel from latched kernel inputs; AFH remap via iterative mod-N and channel-map scan.
module hop_kernel_afh_seq #(
  parameter int NCH  = 79,
  parameter int NMIN = 20,
  parameter int IDXW = 7
) (
  input  logic            clk,
  input  logic            rstz,
  input  logic            req,
  input  logic            afh_en,
  input  logic [4:0]      X,
  input  logic [4:0]      A,
  input  logic [4:0]      C,
  input  logic [3:0]      B,
  input  logic [8:0]      D,
  input  logic [6:0]      E,
  input  logic [6:0]      F,
  input  logic [6:0]      Fprime,
  input  logic            Y1,
  input  logic [5:0]      Y2,
  input  logic [NCH-1:0]  chmap,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] fk,
  output logic            afh_err,
  output logic [IDXW-1:0] nused
);

  localparam int SW = 9;
  localparam logic [IDXW-1:0] HALF_W = IDXW'((NCH + 1) / 2);
  localparam logic [IDXW-1:0] NMIN_W = IDXW'(NMIN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD  = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_MOD  = 3'd3;
  localparam logic [2:0] S_SCAN = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]      state;
  logic            afh_r, y1_r;
  logic [4:0]      x_r, a_r, c_r;
  logic [3:0]      b_r;
  logic [8:0]      d_r;
  logic [6:0]      e_r, f_r, fp_r;
  logic [5:0]      y2_r;
  logic [NCH-1:0]  chmap_r;
  logic [4:0]      perm_r;
  logic [IDXW-1:0] nused_q, kp, j, cnt;
  logic [SW-1:0]   s;

  function automatic logic [4:0] bfly(input logic [4:0] z, input int i, input int k, input logic en);
    logic [4:0] r;
    r = z;
    if (en) begin
      r[i] = z[k];
      r[k] = z[i];
    end
    return r;
  endfunction

  // Seven butterfly stages, control bits consumed from P13 down to P0.
  function automatic logic [4:0] perm5(input logic [4:0] z_in, input logic [13:0] p);
    logic [4:0] z;
    z = z_in;
    z = bfly(bfly(z, 1, 2, p[13]), 0, 3, p[12]);
    z = bfly(bfly(z, 1, 3, p[11]), 2, 4, p[10]);
    z = bfly(bfly(z, 0, 3, p[9]),  1, 4, p[8]);
    z = bfly(bfly(z, 3, 4, p[7]),  0, 2, p[6]);
    z = bfly(bfly(z, 1, 3, p[5]),  0, 4, p[4]);
    z = bfly(bfly(z, 3, 4, p[3]),  1, 2, p[2]);
    z = bfly(bfly(z, 2, 3, p[1]),  0, 1, p[0]);
    return z;
  endfunction

  function automatic logic [IDXW-1:0] hop_ch(input logic [IDXW-1:0] v);
    logic [IDXW-1:0] h;
    h = v - HALF_W;
    return (v < HALF_W) ? {v[IDXW-2:0], 1'b0} : {h[IDXW-2:0], 1'b1};
  endfunction

  logic [4:0]      z;
  logic [4:0]      perm_c;
  logic [IDXW-1:0] popc;
  logic [SW-1:0]   sum_k, sum_s;
  logic [IDXW-1:0] k, bch, ch_j;

  always_comb begin
    z      = (x_r + a_r) ^ {1'b0, b_r};
    perm_c = perm5(z, {c_r ^ {5{y1_r}}, d_r});
    popc   = '0;
    for (int i = 0; i < NCH; i++) popc = popc + IDXW'(chmap_r[i]);
    sum_k  = SW'(e_r) + SW'(f_r) + SW'(y2_r) + SW'(perm_r);
    sum_s  = SW'(e_r) + SW'(fp_r) + SW'(y2_r) + SW'(perm_r);
    k      = IDXW'(sum_k % SW'(NCH));
    bch    = hop_ch(k);
    ch_j   = hop_ch(j);
  end

  assign busy = (state == S_ADD) || (state == S_CHK) || (state == S_MOD) || (state == S_SCAN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state   <= S_IDLE;
      afh_r   <= 1'b0;
      y1_r    <= 1'b0;
      x_r     <= '0;
      a_r     <= '0;
      c_r     <= '0;
      b_r     <= '0;
      d_r     <= '0;
      e_r     <= '0;
      f_r     <= '0;
      fp_r    <= '0;
      y2_r    <= '0;
      chmap_r <= '0;
      perm_r  <= '0;
      nused_q <= '0;
      kp      <= '0;
      j       <= '0;
      cnt     <= '0;
      s       <= '0;
      fk      <= '0;
      afh_err <= 1'b0;
      nused   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (req) begin
            afh_r   <= afh_en;
            y1_r    <= Y1;
            x_r     <= X;
            a_r     <= A;
            c_r     <= C;
            b_r     <= B;
            d_r     <= D;
            e_r     <= E;
            f_r     <= F;
            fp_r    <= Fprime;
            y2_r    <= Y2;
            chmap_r <= chmap;
            state   <= S_ADD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ADD: begin
          perm_r  <= perm_c;
          nused_q <= popc;
          state   <= S_CHK;
        end
        S_CHK: begin
          if (!afh_r || chmap_r[bch] || (nused_q < NMIN_W)) begin
            fk      <= bch;
            afh_err <= afh_r && !chmap_r[bch];
            nused   <= nused_q;
            state   <= S_DONE;
          end else begin
            s     <= sum_s;
            state <= S_MOD;
          end
        end
        S_MOD: begin
          if (s >= SW'(nused_q)) begin
            s <= s - SW'(nused_q);
          end else begin
            kp    <= IDXW'(s);
            j     <= '0;
            cnt   <= '0;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          // kp < nused guarantees a hit before j leaves the channel range.
          if (chmap_r[ch_j] && (cnt == kp)) begin
            fk      <= ch_j;
            afh_err <= 1'b0;
            nused   <= nused_q;
            state   <= S_DONE;
          end else begin
            if (chmap_r[ch_j]) cnt <= cnt + 1'b1;
            j <= j + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hop_kernel_afh_seq.sv
// tb/tb_hop_kernel_afh_seq.sv - scoreboard bench for hop_kernel_afh_seq
module tb_hop_kernel_afh_seq;

  logic        clk, rstz, req, afh_en, Y1;
  logic [4:0]  X, A, C;
  logic [3:0]  B;
  logic [8:0]  D;
  logic [6:0]  E, F, Fprime;
  logic [5:0]  Y2;
  logic [78:0] chmap;
  logic        busy, done, afh_err;
  logic [6:0]  fk, nused;

  int cyc;
  int checks;
  int errors;

  typedef struct {
    int fk;
    int err;
    int nu;
    int lat;
    int rc;
  } exp_t;

  exp_t sb[$];

  hop_kernel_afh_seq #(.NCH(79), .NMIN(20), .IDXW(7)) dut (
    .clk(clk), .rstz(rstz), .req(req), .afh_en(afh_en),
    .X(X), .A(A), .C(C), .B(B), .D(D), .E(E), .F(F), .Fprime(Fprime),
    .Y1(Y1), .Y2(Y2), .chmap(chmap),
    .busy(busy), .done(done), .fk(fk), .afh_err(afh_err), .nused(nused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstz && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("fk", int'(fk), e.fk);
        chk("afh_err", int'(afh_err), e.err);
        chk("nused", int'(nused), e.nu);
        if (e.lat >= 0) chk("latency", cyc - e.rc, e.lat);
        else chk("latency_bound", int'((cyc - e.rc) <= 100), 1);
      end
    end
  end

  task automatic defaults();
    afh_en = 1'b1; Y1 = 1'b0;
    X = '0; A = '0; C = '0; B = '0; D = '0;
    E = '0; F = '0; Fprime = '0; Y2 = '0;
    chmap = '1;
  endtask

  function automatic logic [78:0] low_mask(input int n);
    logic [78:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic issue(input bit now, input int efk, input int eerr, input int enu, input int elat);
    exp_t e;
    if (!now) begin
      @(posedge clk);
      #1;
    end
    req = 1'b1;
    e.fk = efk; e.err = eerr; e.nu = enu; e.lat = elat; e.rc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done expected done within 200 cycles");
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    rstz = 1'b0; req = 1'b0;
    defaults();
    wait_cycles(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fk", int'(fk), 0);
    chk("rst_afh_err", int'(afh_err), 0);
    chk("rst_nused", int'(nused), 0);
    rstz = 1'b1;
    wait_cycles(2);

    // T1 all zero
    issue(0, 0, 0, 79, 3); wait_done();
    // T2 perm=1 -> fk=2, accepted in the DONE cycle of the next op
    X = 5'd1;
    issue(1, 2, 0, 79, 3); wait_done();
    // T3 odd-half wrap
    E = 7'd39;
    issue(1, 1, 0, 79, 3); wait_done();
    X = 5'd0; E = 7'd120;
    issue(0, 3, 0, 79, 3); wait_done();
    // permutation stages and Z xor B
    defaults(); X = 5'd2; C = 5'd16;
    issue(0, 8, 0, 79, 3); wait_done();
    Y1 = 1'b1; C = 5'd15;
    issue(0, 8, 0, 79, 3); wait_done();
    defaults(); X = 5'd1; D = 9'd1;
    issue(0, 4, 0, 79, 3); wait_done();
    defaults(); B = 4'd3;
    issue(0, 6, 0, 79, 3); wait_done();
    defaults(); F = 7'd50; Y2 = 6'd10;
    issue(0, 41, 0, 79, 3); wait_done();

    // T4 remap, k'=10 -> ch1 after 41 scan steps
    defaults(); chmap = low_mask(20); E = 7'd30;
    issue(0, 1, 0, 20, 46); wait_done();
    // remap with five subtractions, k'=0
    defaults(); chmap = low_mask(20); F = 7'd30; Fprime = 7'd100;
    issue(0, 0, 0, 20, 10); wait_done();
    // remap k'=15 -> ch11
    Fprime = 7'd15;
    issue(0, 11, 0, 20, 50); wait_done();

    // T5 below NMIN
    defaults(); chmap = low_mask(19); E = 7'd30;
    issue(0, 60, 1, 19, 3); wait_done();
    afh_en = 1'b0;
    issue(0, 60, 0, 19, 3); wait_done();

    // T6 req during SCAN ignored
    defaults(); chmap = low_mask(20); E = 7'd30;
    issue(0, 1, 0, 20, -1);
    wait_cycles(10);
    defaults();
    req = 1'b1;
    wait_cycles(1);
    req = 1'b0;
    wait_done();
    wait_cycles(8);

    // T6 reset mid-SCAN
    defaults(); chmap = low_mask(20); E = 7'd30;
    @(posedge clk); #1;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    wait_cycles(10);
    rstz = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_fk", int'(fk), 0);
    chk("abort_nused", int'(nused), 0);
    wait_cycles(2);
    rstz = 1'b1;
    defaults(); X = 5'd1;
    issue(0, 2, 0, 79, 3); wait_done();
    wait_cycles(3);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
